// File: rtl/bf_bus_responder.sv
// bf_bus_responder: FPGA-side responder for the BF chip's 12-bit pin bus.
// Answers chip requests with a four-phase req/ack handshake and provides a
// zero-initialised tape RAM, a stdin byte FIFO and a stdout byte port.
module bf_bus_responder #(
  parameter int IN_DEPTH  = 4,
  parameter int MEM_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] chip_io_out,
  output logic [11:0] chip_io_in,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        proto_err
);

  localparam int PW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

  localparam logic [2:0] S_CLEAR      = 3'd0;
  localparam logic [2:0] S_IDLE       = 3'd1;
  localparam logic [2:0] S_RD         = 3'd2;
  localparam logic [2:0] S_WDATA_WAIT = 3'd3;
  localparam logic [2:0] S_WDATA      = 3'd4;
  localparam logic [2:0] S_CIN_WAIT   = 3'd5;
  localparam logic [2:0] S_COUT_WAIT  = 3'd6;
  localparam logic [2:0] S_ACK_HOLD   = 3'd7;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_CIN  = 2'b10;
  localparam logic [1:0] OP_COUT = 2'b11;

  logic [11:0] sync1;
  logic [11:0] sync2;
  logic        req_s;
  logic [1:0]  op_s;
  logic        beat_s;
  logic [7:0]  pay_s;

  logic [2:0]  state;
  logic [2:0]  ret_state;
  logic [7:0]  clr_addr;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        ack;
  logic [7:0]  rdata;
  logic        busy;

  logic [7:0]  mem [MEM_WORDS];
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [7:0]  mem_wdata;

  logic [7:0]  fifo_mem [IN_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_push;
  logic        fifo_pop;
  logic [7:0]  fifo_head;
  logic        dispatch_ok;

  assign req_s  = sync2[11];
  assign op_s   = sync2[10:9];
  assign beat_s = sync2[8];
  assign pay_s  = sync2[7:0];

  assign busy       = (state == S_CLEAR);
  assign chip_io_in = {ack, busy, 2'b00, rdata};

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(IN_DEPTH));
  assign fifo_head  = fifo_mem[rd_ptr];
  assign in_ready   = !fifo_full && (state != S_CLEAR);
  assign fifo_push  = in_valid && in_ready;

  // A command beat is accepted in IDLE, or in WDATA_WAIT as a fresh command
  assign dispatch_ok = req_s && !beat_s &&
                       ((state == S_IDLE) || (state == S_WDATA_WAIT));

  // Two-flop synchronizer for the chip bus, which runs on an unrelated clock
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= chip_io_out;
      sync2 <= sync1;
    end
  end

  // RAM write port selection and FIFO pop decision
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_addr;
    mem_wdata = 8'h00;
    fifo_pop  = 1'b0;
    if (!reset) begin
      if (state == S_CLEAR) begin
        mem_we = 1'b1;
      end else if (state == S_WDATA) begin
        mem_we    = 1'b1;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
      end
      fifo_pop = !fifo_empty &&
                 ((state == S_CIN_WAIT) || (dispatch_ok && (op_s == OP_CIN)));
    end
  end

  // Tape RAM write port (contents are initialised by the CLEAR sweep)
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Stdin FIFO storage
  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= in_data;
    end
  end

  // Stdin FIFO pointers and occupancy; power-of-two depth wraps naturally
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Bus protocol state machine
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_CLEAR;
      ret_state <= S_IDLE;
      clr_addr  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ack       <= 1'b0;
      rdata     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == 8'(MEM_WORDS - 1)) begin
            state <= S_IDLE;
          end
        end
        S_IDLE, S_WDATA_WAIT: begin
          if (req_s && beat_s) begin
            if (state == S_IDLE) begin
              proto_err <= 1'b1;
              ack       <= 1'b1;
              ret_state <= S_IDLE;
              state     <= S_ACK_HOLD;
            end else begin
              wdata_q   <= pay_s;
              ack       <= 1'b1;
              ret_state <= S_IDLE;
              state     <= S_WDATA;
            end
          end else if (dispatch_ok) begin
            if (state == S_WDATA_WAIT) begin
              proto_err <= 1'b1;
            end
            addr_q <= pay_s;
            case (op_s)
              OP_RD: state <= S_RD;
              OP_WR: begin
                ack       <= 1'b1;
                ret_state <= S_WDATA_WAIT;
                state     <= S_ACK_HOLD;
              end
              OP_CIN: begin
                if (!fifo_empty) begin
                  rdata     <= fifo_head;
                  ack       <= 1'b1;
                  ret_state <= S_IDLE;
                  state     <= S_ACK_HOLD;
                end else begin
                  state <= S_CIN_WAIT;
                end
              end
              default: begin
                out_valid <= 1'b1;
                out_data  <= pay_s;
                state     <= S_COUT_WAIT;
              end
            endcase
          end
        end
        S_RD: begin
          rdata     <= mem[addr_q];
          ack       <= 1'b1;
          ret_state <= S_IDLE;
          state     <= S_ACK_HOLD;
        end
        S_WDATA: begin
          state <= S_ACK_HOLD;
        end
        S_CIN_WAIT: begin
          if (!fifo_empty) begin
            rdata     <= fifo_head;
            ack       <= 1'b1;
            ret_state <= S_IDLE;
            state     <= S_ACK_HOLD;
          end
        end
        S_COUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ack       <= 1'b1;
            ret_state <= S_IDLE;
            state     <= S_ACK_HOLD;
          end
        end
        default: begin
          if (!req_s) begin
            ack   <= 1'b0;
            state <= ret_state;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_bus_responder.sv
// tb_bf_bus_responder: scoreboard bench for bf_bus_responder.
// The chip side is driven as a four-phase initiator; expected responses are
// queued at issue time and a monitor compares them as acks and stdout
// transfers appear.
module tb_bf_bus_responder;

  localparam int IN_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] chip_io_out;
  logic [11:0] chip_io_in;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        proto_err;

  logic        ack;
  logic        busy;
  logic [7:0]  rdata;

  assign ack   = chip_io_in[11];
  assign busy  = chip_io_in[10];
  assign rdata = chip_io_in[7:0];

  typedef struct {
    bit         chk;
    logic [7:0] data;
  } exp_t;

  exp_t       rsp_q[$];
  logic [7:0] out_q[$];
  logic [7:0] fifo_model[$];
  logic [7:0] mem_model [256];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int xfer_count = 0;
  int xfer_cyc = 0;
  int ready_mode = 0;
  logic prev_ack = 1'b0;
  exp_t mon_e;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  bf_bus_responder #(.IN_DEPTH(IN_DEPTH), .MEM_WORDS(256)) dut (
    .clock       (clock),
    .reset       (reset),
    .chip_io_out (chip_io_out),
    .chip_io_in  (chip_io_in),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .proto_err   (proto_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: event occurred, none expected", name);
  endtask

  // stdout consumer readiness: 0 = stalled, 1 = always ready, 2 = random
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on each ack rise and each stdout transfer
  always @(negedge clock) begin
    if (ack === 1'b1 && prev_ack !== 1'b1) begin
      if (rsp_q.size() == 0) begin
        fail("ack_without_request");
      end else begin
        mon_e = rsp_q.pop_front();
        if (mon_e.chk) check("rdata", {24'h0, rdata}, {24'h0, mon_e.data});
      end
    end
    prev_ack = ack;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      xfer_count++;
      xfer_cyc = cyc;
      if (out_q.size() == 0) fail("extra_stdout_transfer");
      else check("out_data", {24'h0, out_data}, {24'h0, out_q.pop_front()});
    end
  end

  task automatic start_req(input logic [1:0] op, input logic beat, input logic [7:0] pay,
                           output int t0);
    @(posedge clock); #1;
    chip_io_out = {1'b1, op, beat, pay};
    t0 = cyc;
  endtask

  task automatic wait_ack(input string name, input int budget, output int t_ack, output bit ok);
    ok = 1'b0;
    t_ack = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (ack === 1'b1) begin
        ok = 1'b1;
        t_ack = cyc;
        break;
      end
    end
    if (!ok) begin
      fail({name, "_ack_timeout"});
      rsp_q.delete();
    end
  endtask

  task automatic end_req(input string name);
    bit dropped;
    @(posedge clock); #1;
    chip_io_out = '0;
    dropped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (ack === 1'b0) begin
        dropped = 1'b1;
        break;
      end
    end
    if (!dropped) fail({name, "_ack_stuck_high"});
  endtask

  task automatic do_req(input string name, input logic [1:0] op, input logic beat,
                        input logic [7:0] pay, input int exp_lat, input bit chk,
                        input logic [7:0] d);
    int t0, t_ack;
    bit ok;
    rsp_q.push_back('{chk, d});
    start_req(op, beat, pay, t0);
    wait_ack(name, 200, t_ack, ok);
    if (ok && exp_lat >= 0) check({name, "_latency"}, t_ack - t0, exp_lat);
    end_req(name);
  endtask

  task automatic mem_write(input logic [7:0] a, input logic [7:0] d);
    do_req("wr_cmd", 2'b01, 1'b0, a, 3, 1'b0, 8'h00);
    do_req("wr_data", 2'b01, 1'b1, d, 3, 1'b0, 8'h00);
    mem_model[a] = d;
  endtask

  task automatic mem_read(input logic [7:0] a);
    do_req("rd", 2'b00, 1'b0, a, 4, 1'b1, mem_model[a]);
  endtask

  task automatic push_byte(input logic [7:0] b, output int tp);
    bit acc;
    @(posedge clock); #1;
    in_valid = 1'b1;
    in_data  = b;
    tp  = cyc;
    acc = in_ready;
    check("in_ready", {31'h0, acc}, {31'h0, (fifo_model.size() < IN_DEPTH)});
    if (acc) fifo_model.push_back(b);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic char_in();
    logic [7:0] e;
    e = fifo_model.pop_front();
    do_req("cin", 2'b10, 1'b0, 8'h00, 3, 1'b1, e);
  endtask

  task automatic char_out(input logic [7:0] b, input int lat);
    out_q.push_back(b);
    do_req("cout", 2'b11, 1'b0, b, lat, 1'b0, 8'h00);
  endtask

  task automatic count_clear(input string name);
    int n;
    bit saw_ack;
    n = 0;
    saw_ack = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (busy === 1'b1) begin
        n++;
        if (ack !== 1'b0) saw_ack = 1'b1;
      end else begin
        break;
      end
    end
    check({name, "_busy_cycles"}, n, 256);
    check({name, "_ack_during_clear"}, {31'h0, saw_ack}, 0);
  endtask

  // Watchdog so the bench always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    int t0, t_ack, tp, x0;
    bit ok, saw;
    logic [7:0] a, d;

    reset = 1'b1;
    chip_io_out = '0;
    in_valid = 1'b0;
    in_data = '0;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    repeat (3) @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b0;

    check("reset_ack", {31'h0, ack}, 0);
    check("reset_busy", {31'h0, busy}, 1);
    check("reset_rdata", {24'h0, rdata}, 0);
    check("reset_out_valid", {31'h0, out_valid}, 0);
    check("reset_out_data", {24'h0, out_data}, 0);
    check("reset_proto_err", {31'h0, proto_err}, 0);
    check("reset_in_ready", {31'h0, in_ready}, 0);

    // A read raised during CLEAR must only be answered once CLEAR finishes
    rsp_q.push_back('{1'b1, 8'h00});
    chip_io_out = {1'b1, 2'b00, 1'b0, 8'h7F};
    count_clear("clear1");
    wait_ack("rd_7f", 50, t_ack, ok);
    end_req("rd_7f");

    mem_write(8'h12, 8'hA5);
    mem_read(8'h12);
    mem_read(8'h13);

    // Char-in stalls on an empty FIFO, then wakes on a push
    rsp_q.push_back('{1'b1, 8'h41});
    start_req(2'b10, 1'b0, 8'h00, t0);
    saw = 1'b0;
    repeat (50) begin
      @(negedge clock);
      if (ack !== 1'b0) saw = 1'b1;
    end
    check("cin_stall_ack", {31'h0, saw}, 0);
    push_byte(8'h41, tp);
    void'(fifo_model.pop_front());
    wait_ack("cin_wake", 20, t_ack, ok);
    if (ok) check("cin_wake_within_2", {31'h0, (t_ack - tp <= 2)}, 1);
    end_req("cin_wake");

    for (int i = 1; i <= 5; i++) push_byte(8'(i), tp);
    repeat (4) char_in();

    // Char-out held against a stalled consumer, then a single transfer
    ready_mode = 0;
    out_q.push_back(8'h48);
    rsp_q.push_back('{1'b0, 8'h00});
    start_req(2'b11, 1'b0, 8'h48, t0);
    saw = 1'b0;
    repeat (13) begin
      @(negedge clock);
      if (ack !== 1'b0) saw = 1'b1;
    end
    check("cout_stall_ack", {31'h0, saw}, 0);
    check("cout_stall_valid", {31'h0, out_valid}, 1);
    check("cout_stall_data", {24'h0, out_data}, 32'h48);
    x0 = xfer_count;
    ready_mode = 1;
    wait_ack("cout_go", 20, t_ack, ok);
    if (ok) check("cout_ack_after_xfer", t_ack - xfer_cyc, 1);
    end_req("cout_go");
    check("cout_single_xfer", xfer_count - x0, 1);
    check("cout_valid_dropped", {31'h0, out_valid}, 0);

    char_out(8'h21, 4);

    // Protocol errors: stray data beat, and a command replacing a pending write
    do_req("stray", 2'b00, 1'b1, 8'h5A, 3, 1'b0, 8'h00);
    check("proto_err_set", {31'h0, proto_err}, 1);
    mem_read(8'h12);
    mem_read(8'h5A);
    do_req("wr_cmd", 2'b01, 1'b0, 8'h30, 3, 1'b0, 8'h00);
    do_req("fresh_rd", 2'b00, 1'b0, 8'h12, 4, 1'b1, mem_model[8'h12]);
    mem_read(8'h30);
    check("proto_err_sticky", {31'h0, proto_err}, 1);

    // Randomized traffic against the reference model
    ready_mode = 2;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 8'($urandom_range(0, 31));
          d = 8'($urandom);
          mem_write(a, d);
        end
        1: mem_read(8'($urandom_range(0, 31)));
        2: begin
          for (int k = 0, n = $urandom_range(1, 3); k < n; k++) push_byte(8'($urandom), tp);
          if (fifo_model.size() > 0) char_in();
        end
        default: char_out(8'($urandom), -1);
      endcase
    end
    while (fifo_model.size() > 0) char_in();

    // Reset while a read is in RD: ack must stay low and CLEAR restarts
    ready_mode = 1;
    push_byte(8'h99, tp);
    start_req(2'b00, 1'b0, 8'h20, t0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrd_ack", {31'h0, ack}, 0);
    check("midrd_busy", {31'h0, busy}, 1);
    check("midrd_proto_err", {31'h0, proto_err}, 0);
    check("midrd_in_ready", {31'h0, in_ready}, 0);
    chip_io_out = '0;
    reset = 1'b0;
    fifo_model.delete();
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    count_clear("clear2");

    // The byte pushed before reset must be gone
    rsp_q.push_back('{1'b1, 8'h77});
    start_req(2'b10, 1'b0, 8'h00, t0);
    saw = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (ack !== 1'b0) saw = 1'b1;
    end
    check("post_reset_fifo_empty", {31'h0, saw}, 0);
    push_byte(8'h77, tp);
    void'(fifo_model.pop_front());
    wait_ack("post_reset_cin", 20, t_ack, ok);
    end_req("post_reset_cin");
    mem_read(8'h12);

    repeat (5) @(posedge clock);
    check("rsp_queue_drained", rsp_q.size(), 0);
    check("out_queue_drained", out_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
